// File: rtl/alu_mult_sequencer.sv
// Iterative unsigned shift-and-add multiplier that drives an external
// combinational ALU with one ADD per cycle for WIDTH cycles and returns
// the full 2*WIDTH-bit product over a valid/ready handshake.
module alu_mult_sequencer #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned CNT_W = 6
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [WIDTH-1:0]     in_a,
  input  logic [WIDTH-1:0]     in_b,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [2*WIDTH-1:0]   product,
  output logic                 busy,
  output logic [WIDTH-1:0]     alu_operandA,
  output logic [WIDTH-1:0]     alu_operandB,
  output logic [2:0]           alu_command,
  input  logic [WIDTH-1:0]     alu_result,
  input  logic                 alu_carryout
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam logic [CNT_W-1:0] LAST_ITER = CNT_W'(WIDTH - 1);

  state_t             state_q, state_d;
  logic [WIDTH-1:0]   acc_hi_q, acc_hi_d;
  logic [WIDTH-1:0]   lo_q, lo_d;
  logic [WIDTH-1:0]   mcand_q, mcand_d;
  logic [CNT_W-1:0]   count_q, count_d;

  // Handshake status and product are pure decodes of the registered state.
  assign in_ready    = (state_q == IDLE);
  assign out_valid   = (state_q == DONE);
  assign busy        = ~in_ready;
  assign product     = {acc_hi_q, lo_q};
  assign alu_command = 3'd0;

  // State and datapath registers; reset returns everything to IDLE/zero.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= IDLE;
      acc_hi_q <= '0;
      lo_q     <= '0;
      mcand_q  <= '0;
      count_q  <= '0;
    end else begin
      state_q  <= state_d;
      acc_hi_q <= acc_hi_d;
      lo_q     <= lo_d;
      mcand_q  <= mcand_d;
      count_q  <= count_d;
    end
  end

  // Next-state logic and ALU operand drive.
  // Each RUN step adds the multiplicand into the high half when the current
  // multiplier LSB is set, then shifts {carry, sum, lo} right by one; the
  // sum's LSB moves into lo as the multiplier bit is consumed.
  always_comb begin
    state_d      = state_q;
    acc_hi_d     = acc_hi_q;
    lo_d         = lo_q;
    mcand_d      = mcand_q;
    count_d      = count_q;
    alu_operandA = '0;
    alu_operandB = '0;
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          mcand_d  = in_a;
          lo_d     = in_b;
          acc_hi_d = '0;
          count_d  = '0;
          state_d  = RUN;
        end
      end
      RUN: begin
        alu_operandA = acc_hi_q;
        alu_operandB = lo_q[0] ? mcand_q : '0;
        acc_hi_d     = {alu_carryout, alu_result[WIDTH-1:1]};
        lo_d         = {alu_result[0], lo_q[WIDTH-1:1]};
        count_d      = count_q + CNT_W'(1);
        if (count_q == LAST_ITER) begin
          state_d = DONE;
        end
      end
      DONE: begin
        if (out_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

endmodule

// File: tb/tb_alu_mult_sequencer.sv
// Directed bench for alu_mult_sequencer with a behavioural 32-bit adder
// standing in for the external ALU.
module tb_alu_mult_sequencer;

  localparam int W = 32;

  logic           clk;
  logic           reset_n;
  logic           in_valid;
  logic           in_ready;
  logic [W-1:0]   in_a;
  logic [W-1:0]   in_b;
  logic           out_valid;
  logic           out_ready;
  logic [2*W-1:0] product;
  logic           busy;
  logic [W-1:0]   alu_operandA;
  logic [W-1:0]   alu_operandB;
  logic [2:0]     alu_command;
  logic [W-1:0]   alu_result;
  logic           alu_carryout;

  int vectors = 0;
  int errors  = 0;

  alu_mult_sequencer #(.WIDTH(W), .CNT_W(6)) dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .in_a         (in_a),
    .in_b         (in_b),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .product      (product),
    .busy         (busy),
    .alu_operandA (alu_operandA),
    .alu_operandB (alu_operandB),
    .alu_command  (alu_command),
    .alu_result   (alu_result),
    .alu_carryout (alu_carryout)
  );

  // External ALU stand-in: ADD only.
  assign {alu_carryout, alu_result} = {1'b0, alu_operandA} + {1'b0, alu_operandB};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Present operands for one edge, then wait (bounded) for out_valid.
  // Called 1 time unit after a rising edge; returns 1 time unit after the
  // edge where out_valid first rose. lat = edges after acceptance, or -1.
  task automatic issue(input logic [W-1:0] a, input logic [W-1:0] b,
                       output logic accepted, output int lat);
    in_a     = a;
    in_b     = b;
    in_valid = 1'b1;
    accepted = in_ready;
    @(posedge clk); #1;
    in_valid = 1'b0;
    lat = -1;
    for (int i = 1; i <= W + 8; i++) begin
      @(posedge clk); #1;
      if (out_valid) begin
        lat = i;
        break;
      end
    end
  endtask

  task automatic test_reset();
    vectors++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL reset_flags: got rdy=%b vld=%b busy=%b want 1 0 0", in_ready, out_valid, busy);
    end
    vectors++;
    if (product !== 64'd0) begin
      errors++;
      $display("FAIL reset_product: got %h want 0", product);
    end
    vectors++;
    if (alu_operandA !== 32'd0 || alu_operandB !== 32'd0 || alu_command !== 3'd0) begin
      errors++;
      $display("FAIL reset_alu: got A=%h B=%h cmd=%0d want 0 0 0", alu_operandA, alu_operandB, alu_command);
    end
  endtask

  task automatic test_basic();
    logic acc; int lat;
    out_ready = 1'b1;
    issue(32'd3, 32'd5, acc, lat);
    vectors++;
    if (acc !== 1'b1 || lat !== W) begin
      errors++;
      $display("FAIL basic_latency: got acc=%b lat=%0d want 1 %0d", acc, lat, W);
    end
    vectors++;
    if (product !== 64'h0000_0000_0000_000F) begin
      errors++;
      $display("FAIL basic_product: got %h want 000000000000000f", product);
    end
    vectors++;
    if (in_ready !== 1'b0 || busy !== 1'b1) begin
      errors++;
      $display("FAIL basic_done_flags: got rdy=%b busy=%b want 0 1", in_ready, busy);
    end
    @(posedge clk); #1;
    vectors++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      errors++;
      $display("FAIL basic_return_idle: got rdy=%b vld=%b want 1 0", in_ready, out_valid);
    end
  endtask

  task automatic test_max();
    logic acc; int lat;
    out_ready = 1'b1;
    issue(32'hFFFF_FFFF, 32'hFFFF_FFFF, acc, lat);
    vectors++;
    if (lat !== W || product !== 64'hFFFF_FFFE_0000_0001) begin
      errors++;
      $display("FAIL max_product: got lat=%0d %h want %0d fffffffe00000001", lat, product, W);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_zero();
    logic acc; int lat;
    out_ready = 1'b1;
    issue(32'h1234_5678, 32'd0, acc, lat);
    vectors++;
    if (lat !== W || product !== 64'd0) begin
      errors++;
      $display("FAIL zero_b: got lat=%0d %h want %0d 0", lat, product, W);
    end
    @(posedge clk); #1;
    issue(32'd0, 32'hDEAD_BEEF, acc, lat);
    vectors++;
    if (lat !== W || product !== 64'd0) begin
      errors++;
      $display("FAIL zero_a: got lat=%0d %h want %0d 0", lat, product, W);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_backpressure();
    logic acc; int lat;
    out_ready = 1'b0;
    issue(32'h8000_0000, 32'd2, acc, lat);
    vectors++;
    if (lat !== W || product !== 64'h1_0000_0000) begin
      errors++;
      $display("FAIL bp_product: got lat=%0d %h want %0d 0000000100000000", lat, product, W);
    end
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      vectors++;
      if (product !== 64'h1_0000_0000 || out_valid !== 1'b1 || in_ready !== 1'b0) begin
        errors++;
        $display("FAIL bp_hold[%0d]: got %h vld=%b rdy=%b want 0000000100000000 1 0", i, product, out_valid, in_ready);
      end
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    vectors++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      errors++;
      $display("FAIL bp_release: got rdy=%b vld=%b want 1 0", in_ready, out_valid);
    end
  endtask

  task automatic test_ignore_busy();
    int lat;
    int bad_cmd;
    out_ready = 1'b1;
    in_a = 32'd7; in_b = 32'd9; in_valid = 1'b1;
    @(posedge clk); #1;
    // Keep requesting with other operands throughout RUN.
    in_a = 32'd100; in_b = 32'd200;
    vectors++;
    if (alu_operandA !== 32'd0 || alu_operandB !== 32'd7) begin
      errors++;
      $display("FAIL first_iter_drive: got A=%h B=%h want 0 7", alu_operandA, alu_operandB);
    end
    bad_cmd = 0;
    lat = -1;
    for (int i = 1; i <= W + 8; i++) begin
      if (alu_command !== 3'd0) bad_cmd++;
      @(posedge clk); #1;
      if (out_valid) begin
        lat = i;
        break;
      end
    end
    in_valid = 1'b0;
    vectors++;
    if (lat !== W || product !== 64'd63) begin
      errors++;
      $display("FAIL ignore_product: got lat=%0d %0d want %0d 63", lat, product, W);
    end
    vectors++;
    if (bad_cmd !== 0 || alu_command !== 3'd0) begin
      errors++;
      $display("FAIL alu_command: got %0d non-ADD cycles want 0", bad_cmd);
    end
    @(posedge clk); #1;
    vectors++;
    if (in_ready !== 1'b1) begin
      errors++;
      $display("FAIL ignore_idle: got rdy=%b want 1", in_ready);
    end
  endtask

  task automatic test_reset_mid();
    logic acc; int lat;
    out_ready = 1'b1;
    in_a = 32'hFFFF_FFFF; in_b = 32'hFFFF_FFFF; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
    end
    reset_n = 1'b0;
    #1;
    vectors++;
    if (out_valid !== 1'b0 || product !== 64'd0 || in_ready !== 1'b1 || busy !== 1'b0) begin
      errors++;
      $display("FAIL mid_reset: got vld=%b %h rdy=%b busy=%b want 0 0 1 0", out_valid, product, in_ready, busy);
    end
    #1 reset_n = 1'b1;
    @(posedge clk); #1;
    issue(32'd2, 32'd3, acc, lat);
    vectors++;
    if (acc !== 1'b1 || lat !== W || product !== 64'd6) begin
      errors++;
      $display("FAIL after_reset: got acc=%b lat=%0d %0d want 1 %0d 6", acc, lat, product, W);
    end
    @(posedge clk); #1;
  endtask

  initial begin
    reset_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    in_a = '0; in_b = '0;
    #12 reset_n = 1'b1;
    @(posedge clk); #1;
    test_reset();
    test_basic();
    test_max();
    test_zero();
    test_backpressure();
    test_ignore_busy();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
